// File: rtl/div3_pkg.sv
// Shared types and constants for the iterative divide-by-3 block.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div3_state_t;

    localparam int unsigned DIVISOR = 3;

endpackage

// File: rtl/div3_step.sv
// One restoring divide-by-3 step: bring in one dividend bit, compare and subtract.
module div3_step
    import div3_pkg::*;
(
    input  logic [1:0] r_in,
    input  logic       bit_in,
    output logic [1:0] r_out,
    output logic       q_bit
);

    logic [2:0] t;

    // t = 2*r + bit is at most 5 while r stays in 0..2; the difference fits in 2 bits.
    always_comb begin
        t     = {r_in, bit_in};
        q_bit = (t >= 3'(DIVISOR));
        r_out = q_bit ? 2'(t - 3'(DIVISOR)) : t[1:0];
    end

endmodule

// File: rtl/divide3_seq.sv
// Iterative unsigned divide-by-3, MSB first, one dividend bit per clock.
// Handshake: start accepted in IDLE or DONE; busy while running; done pulses for one cycle.
module divide3_seq
    import div3_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [1:0]       remainder
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    div3_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] qwork_q, qwork_d;
    logic [1:0]       r_q, r_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [1:0]       remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       step_r;
    logic             step_q;

    div3_step u_step (
        .r_in   (r_q),
        .bit_in (shift_q[WIDTH-1]),
        .r_out  (step_r),
        .q_bit  (step_q)
    );

    // Next-state: FSM, datapath step, and result capture on the final step only.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        qwork_d     = qwork_q;
        r_d         = r_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    shift_d = dividend;
                    qwork_d = '0;
                    r_d     = 2'd0;
                    count_d = CntW'(WIDTH);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shift_d = shift_q << 1;
                r_d     = step_r;
                qwork_d = {qwork_q[WIDTH-2:0], step_q};
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = {qwork_q[WIDTH-2:0], step_q};
                    remainder_d = step_r;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state, so they never glitch.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // All state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            qwork_q     <= '0;
            r_q         <= 2'd0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            qwork_q     <= qwork_d;
            r_q         <= r_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    // Partial remainder must stay in 0..2, so t = 6..7 can never occur.
    r_range_a: assert property (@(posedge clk) disable iff (!rst_n) (r_q != 2'd3));

endmodule

// File: tb/tb_divide3_seq.sv
// Self-checking bench for divide3_seq at WIDTH=4 and WIDTH=8 with a result scoreboard.
module tb_divide3_seq;

    typedef struct {
        int d;
        int q;
        int r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] dividend4 = '0;
    logic [7:0] dividend8 = '0;
    logic       busy4, done4, busy8, done8;
    logic [3:0] quotient4;
    logic [7:0] quotient8;
    logic [1:0] remainder4, remainder8;

    exp_t sb4[$];
    exp_t sb8[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_q4  = 0, last_r4 = 0;
    int   last_q8  = 0, last_r8 = 0;
    logic done4_prev = 1'b0, done8_prev = 1'b0;

    always #5 clk = ~clk;

    divide3_seq #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .dividend  (dividend4),
        .busy      (busy4),
        .done      (done4),
        .quotient  (quotient4),
        .remainder (remainder4)
    );

    divide3_seq #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .dividend  (dividend8),
        .busy      (busy8),
        .done      (done8),
        .quotient  (quotient8),
        .remainder (remainder8)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input int d);
        exp_t e;
        e.d = d;
        e.q = d / 3;
        e.r = d % 3;
        return e;
    endfunction

    // Scoreboard for the 4-bit instance: every done pulse retires one expected result.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            exp_t e;
            check_eq("done4_width", int'(done4_prev), 0);
            if (sb4.size() == 0) begin
                check_eq("sb4_unexpected_done", 1, 0);
            end else begin
                e = sb4.pop_front();
                check_eq($sformatf("q4[d=%0d]", e.d), int'(quotient4), e.q);
                check_eq($sformatf("r4[d=%0d]", e.d), int'(remainder4), e.r);
                check_eq($sformatf("recon4[d=%0d]", e.d),
                         3 * int'(quotient4) + int'(remainder4), e.d);
            end
        end
        done4_prev <= done4;
    end

    // Scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            exp_t e;
            check_eq("done8_width", int'(done8_prev), 0);
            if (sb8.size() == 0) begin
                check_eq("sb8_unexpected_done", 1, 0);
            end else begin
                e = sb8.pop_front();
                check_eq($sformatf("q8[d=%0d]", e.d), int'(quotient8), e.q);
                check_eq($sformatf("r8[d=%0d]", e.d), int'(remainder8), e.r);
            end
        end
        done8_prev <= done8;
    end

    // Run one operation; call and return on a falling edge (returns in the done cycle).
    task automatic run_op(input bit wide, input int d);
        int  nb;
        bit  seen;
        int  width;
        width = wide ? 8 : 4;
        if (wide) begin
            sb8.push_back(model(d));
            dividend8 = 8'(d);
            start8    = 1'b1;
        end else begin
            sb4.push_back(model(d));
            dividend4 = 4'(d);
            start4    = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (wide ? busy8 : busy4) begin
                nb++;
                // Outputs must keep the previous result while running.
                check_eq("hold_q", wide ? int'(quotient8) : int'(quotient4),
                         wide ? last_q8 : last_q4);
            end
            if (wide ? done8 : done4) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("done_seen", int'(seen), 1);
        check_eq("busy_cycles", nb, width);
        if (wide) begin
            last_q8 = d / 3;
            last_r8 = d % 3;
        end else begin
            last_q4 = d / 3;
            last_r4 = d % 3;
        end
    endtask

    task automatic wait_done4(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done4) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        bit seen;

        // Reset state, before any clock edge.
        #2;
        check_eq("rst_busy4", int'(busy4), 0);
        check_eq("rst_done4", int'(done4), 0);
        check_eq("rst_q4", int'(quotient4), 0);
        check_eq("rst_r4", int'(remainder4), 0);
        check_eq("rst_busy8", int'(busy8), 0);
        check_eq("rst_q8", int'(quotient8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(1'b0, 15);
        check_eq("d15_q", int'(quotient4), 5);
        check_eq("d15_r", int'(remainder4), 0);
        @(negedge clk);
        check_eq("idle_hold_q", int'(quotient4), 5);
        check_eq("idle_done_low", int'(done4), 0);
        run_op(1'b0, 14);
        check_eq("d14_q", int'(quotient4), 4);
        check_eq("d14_r", int'(remainder4), 2);
        @(negedge clk);
        run_op(1'b0, 0);
        check_eq("d0_q", int'(quotient4), 0);
        check_eq("d0_r", int'(remainder4), 0);
        @(negedge clk);

        // Exhaustive, issued back-to-back from each done cycle.
        for (int d = 0; d < 16; d++) run_op(1'b0, d);
        @(negedge clk);

        // start held through RUN while the dividend changes: operand captured at accept.
        sb4.push_back(model(13));
        dividend4 = 4'd13;
        start4    = 1'b1;
        @(negedge clk);
        dividend4 = 4'd7;
        wait_done4(seen);
        check_eq("held_start_done", int'(seen), 1);
        check_eq("held_q13", int'(quotient4), 4);
        check_eq("held_r13", int'(remainder4), 1);
        // start still high in the done cycle: 7 is accepted with no idle cycle.
        sb4.push_back(model(7));
        @(negedge clk);
        start4 = 1'b0;
        check_eq("b2b_busy", int'(busy4), 1);
        check_eq("b2b_done_low", int'(done4), 0);
        wait_done4(seen);
        check_eq("b2b_done", int'(seen), 1);
        last_q4 = 2;
        last_r4 = 1;
        @(negedge clk);

        // Asynchronous reset in the middle of dividend 11.
        dividend4 = 4'd11;
        start4    = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", int'(busy4), 0);
        check_eq("arst_done", int'(done4), 0);
        check_eq("arst_q", int'(quotient4), 0);
        check_eq("arst_r", int'(remainder4), 0);
        last_q4 = 0;
        last_r4 = 0;
        @(negedge clk);
        check_eq("arst_idle_busy", int'(busy4), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 9);
        check_eq("d9_q", int'(quotient4), 3);
        check_eq("d9_r", int'(remainder4), 0);
        @(negedge clk);

        // Wide instance.
        run_op(1'b1, 255);
        check_eq("d255_q", int'(quotient8), 85);
        check_eq("d255_r", int'(remainder8), 0);
        @(negedge clk);
        run_op(1'b1, 200);
        check_eq("d200_q", int'(quotient8), 66);
        check_eq("d200_r", int'(remainder8), 2);
        @(negedge clk);
        @(negedge clk);

        check_eq("sb4_drained", sb4.size(), 0);
        check_eq("sb8_drained", sb8.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
